// File: rtl/pa_fpu.sv
// Shared FPU package: default mantissa widths and the divide/sqrt engine types.
package pa_fpu;

  localparam int unsigned FPU_MANT_W  = 24;
  localparam int unsigned FPU_GUARD_W = 2;

  typedef enum logic [1:0] {
    ds_idle_st,
    ds_load_st,
    ds_iter_st,
    ds_valid_st
  } e_divsqrt_st;

  typedef enum logic {
    ds_op_div,
    ds_op_sqrt
  } e_divsqrt_op;

endpackage

// File: rtl/fpu_divsqrt_step.sv
// Combinational single-bit restoring trial subtract, shared by divide and square root.
module fpu_divsqrt_step
  import pa_fpu::*;
#(
  parameter int unsigned MANT_W = FPU_MANT_W,
  parameter int unsigned QUO_W  = FPU_MANT_W + FPU_GUARD_W
) (
  input  e_divsqrt_op       i_op,
  input  logic [QUO_W+1:0]  i_rem,
  input  logic [1:0]        i_rad_top,
  input  logic [QUO_W-1:0]  i_root,
  input  logic [MANT_W-1:0] i_divisor,
  output logic              o_bit,
  output logic [QUO_W+1:0]  o_rem
);

  localparam int unsigned REM_W = QUO_W + 2;

  logic [REM_W-1:0] w_pair;
  logic [REM_W-1:0] w_sub;
  logic [REM_W:0]   w_trial;
  logic [REM_W-1:0] w_keep;

  always_comb begin
    w_pair = i_rem;
    w_sub  = {{(REM_W-MANT_W){1'b0}}, i_divisor};
    if (i_op == ds_op_sqrt) begin
      // Bring down the next radicand digit pair; trial subtrahend is 4*root+1.
      w_pair = {i_rem[REM_W-3:0], i_rad_top};
      w_sub  = {i_root, 2'b01};
    end
    w_trial = {1'b0, w_pair} - {1'b0, w_sub};
    o_bit   = ~w_trial[REM_W];
    w_keep  = o_bit ? w_trial[REM_W-1:0] : w_pair;
    o_rem   = (i_op == ds_op_sqrt) ? w_keep : {w_keep[REM_W-2:0], 1'b0};
  end

endmodule

// File: rtl/fpu_divsqrt_iter.sv
// Iterative restoring mantissa divide / square-root engine, one result bit per cycle.
// Optional macro FPU_DIVSQRT_EARLY_TERM_EN: leave iteration once the remainder is exhausted.
module fpu_divsqrt_iter
  import pa_fpu::*;
#(
  parameter int unsigned MANT_W  = FPU_MANT_W,
  parameter int unsigned GUARD_W = FPU_GUARD_W
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      start,
  input  logic                      op_sqrt,
  input  logic                      exp_odd,
  input  logic [MANT_W-1:0]         a,
  input  logic [MANT_W-1:0]         b,
  output logic                      busy,
  output logic                      done,
  input  logic                      ack,
  output logic [MANT_W+GUARD_W-1:0] result,
  output logic                      sticky,
  output logic                      div_zero
);

  localparam int unsigned QUO_W  = MANT_W + GUARD_W;
  localparam int unsigned REM_W  = QUO_W + 2;
  localparam int unsigned RAD_W  = 2 * QUO_W;
  localparam int unsigned RAD_SH = RAD_W - MANT_W - 1;
  localparam int unsigned CNT_W  = $clog2(QUO_W + 1);

  e_divsqrt_st      r_state;
  e_divsqrt_st      w_state_nxt;
  e_divsqrt_op      r_op;
  logic             r_exp_odd;
  logic [MANT_W-1:0] r_a;
  logic [MANT_W-1:0] r_b;
  logic [REM_W-1:0] r_rem;
  logic [RAD_W-1:0] r_rad;
  logic [QUO_W-1:0] r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sticky;
  logic             r_div_zero;

  logic             w_b_zero;
  logic             w_bit;
  logic             w_iter_last;
  logic [REM_W-1:0] w_rem_nxt;
  logic [RAD_W-1:0] w_rad_ext;
  logic [RAD_W-1:0] w_rad_init;
  logic [RAD_W-1:0] w_rad_nxt;
  logic [QUO_W-1:0] w_quo_nxt;

  assign w_b_zero   = (r_op == ds_op_div) && (r_b == '0);
  assign w_rad_ext  = {{(RAD_W-MANT_W){1'b0}}, r_a};
  assign w_rad_init = r_exp_odd ? (w_rad_ext << (RAD_SH + 1)) : (w_rad_ext << RAD_SH);
  assign w_rad_nxt  = {r_rad[RAD_W-3:0], 2'b00};
  assign w_quo_nxt  = {r_result[QUO_W-2:0], w_bit};

`ifdef FPU_DIVSQRT_EARLY_TERM_EN
  logic w_rem_zero;
  // A sqrt is only exact once the unconsumed radicand digits are zero as well.
  assign w_rem_zero  = (w_rem_nxt == '0) && ((r_op == ds_op_div) || (w_rad_nxt == '0));
  assign w_iter_last = (r_cnt == CNT_W'(1)) || w_rem_zero;
`else
  assign w_iter_last = (r_cnt == CNT_W'(1));
`endif

  fpu_divsqrt_step #(
    .MANT_W (MANT_W),
    .QUO_W  (QUO_W)
  ) u_step (
    .i_op      (r_op),
    .i_rem     (r_rem),
    .i_rad_top (r_rad[RAD_W-1 -: 2]),
    .i_root    (r_result),
    .i_divisor (r_b),
    .o_bit     (w_bit),
    .o_rem     (w_rem_nxt)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= ds_idle_st;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ds_idle_st:  if (start) w_state_nxt = ds_load_st;
      ds_load_st:  w_state_nxt = w_b_zero ? ds_valid_st : ds_iter_st;
      ds_iter_st:  if (w_iter_last) w_state_nxt = ds_valid_st;
      ds_valid_st: if (ack) w_state_nxt = ds_idle_st;
      default:     w_state_nxt = ds_idle_st;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_op       <= ds_op_div;
      r_exp_odd  <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_rem      <= '0;
      r_rad      <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_sticky   <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        ds_idle_st: begin
          if (start) begin
            r_op      <= op_sqrt ? ds_op_sqrt : ds_op_div;
            r_exp_odd <= exp_odd;
            r_a       <= a;
            r_b       <= b;
          end
        end
        ds_load_st: begin
          r_cnt      <= CNT_W'(QUO_W);
          r_sticky   <= 1'b0;
          r_div_zero <= w_b_zero;
          r_result   <= w_b_zero ? '1 : '0;
          if (r_op == ds_op_div) begin
            r_rem <= {{(REM_W-MANT_W){1'b0}}, r_a};
            r_rad <= '0;
          end else begin
            r_rem <= '0;
            r_rad <= w_rad_init;
          end
        end
        ds_iter_st: begin
          r_rem    <= w_rem_nxt;
          r_rad    <= w_rad_nxt;
          r_cnt    <= r_cnt - CNT_W'(1);
          r_result <= w_quo_nxt;
          if (w_iter_last) r_sticky <= (w_rem_nxt != '0);
`ifdef FPU_DIVSQRT_EARLY_TERM_EN
          if (w_rem_zero) r_result <= w_quo_nxt << (r_cnt - CNT_W'(1));
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != ds_idle_st);
  assign done     = (r_state == ds_valid_st);
  assign result   = r_result;
  assign sticky   = r_sticky;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_fpu_divsqrt_iter.sv
// Self-checking bench for fpu_divsqrt_iter: arithmetic reference model plus directed vectors.
module tb_fpu_divsqrt_iter;

  localparam int MW = 24;
  localparam int GW = 2;
  localparam int QW = MW + GW;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          start = 1'b0;
  logic          op_sqrt = 1'b0;
  logic          exp_odd = 1'b0;
  logic          ack = 1'b0;
  logic [MW-1:0] a = '0;
  logic [MW-1:0] b = '0;
  logic          busy, done, sticky, div_zero;
  logic [QW-1:0] result;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int          cyc = 0;

  fpu_divsqrt_iter #(.MANT_W(MW), .GUARD_W(GW)) dut (
    .clk(clk), .arst(arst), .start(start), .op_sqrt(op_sqrt), .exp_odd(exp_odd),
    .a(a), .b(b), .busy(busy), .done(done), .ack(ack), .result(result),
    .sticky(sticky), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [QW-1:0] res;
    logic          st;
    logic          dz;
    int            t0;
    int            lat;
  } exp_t;

  typedef struct {
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic          sq;
    logic          e;
    logic [QW-1:0] hres;
    logic          hst;
  } vec_t;

  exp_t q[$];
  exp_t cur;
  bit   cur_v = 0;
  vec_t vecs[10];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
    end
  endfunction

  // Reference: exact integer quotient / integer square root; latency from the result's trailing zeros.
  function automatic exp_t model(input logic [MW-1:0] ia, input logic [MW-1:0] ib,
                                 input logic isq, input logic ie);
    exp_t        e;
    logic [63:0] n, x, r;
    real         xr;
    int          tz;
    e.t0 = 0;
    e.dz = 1'b0;
    if (!isq && ib == '0) begin
      e.res = '1; e.st = 1'b0; e.dz = 1'b1; e.lat = 2;
      return e;
    end
    if (!isq) begin
      n    = 64'(ia) << (QW - 1);
      r    = n / 64'(ib);
      e.st = (n % 64'(ib)) != 0;
    end else begin
      x  = 64'(ia) << (2*QW - MW - 1 + int'(ie));
      xr = real'(x);
      r  = 64'($rtoi($sqrt(xr)));
      while (r * r > x) r--;
      while ((r + 1) * (r + 1) <= x) r++;
      e.st = (r * r != x);
    end
    e.res = r[QW-1:0];
    e.lat = QW + 2;
`ifdef FPU_DIVSQRT_EARLY_TERM_EN
    if (!e.st) begin
      tz = 0;
      while (tz < QW && !r[tz]) tz++;
      e.lat = 2 + QW - tz;
    end
`endif
    return e;
  endfunction

  // Single compare process: every cycle done is high, outputs must match the pending expectation.
  always @(negedge clk) begin
    if (arst) begin
      q.delete();
      cur_v = 0;
    end else if (done) begin
      if (!cur_v) begin
        chk("done_has_pending_op", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          cur   = q.pop_front();
          cur_v = 1;
          chk("latency", 64'(cyc - cur.t0), 64'(cur.lat));
        end
      end
      if (cur_v) begin
        chk("result", 64'(result), 64'(cur.res));
        chk("sticky", 64'(sticky), 64'(cur.st));
        chk("div_zero", 64'(div_zero), 64'(cur.dz));
        chk("busy_with_done", 64'(busy), 64'd1);
      end
    end else begin
      cur_v = 0;
    end
  end

  task automatic start_op(input vec_t v, input bit sync);
    exp_t e;
    if (sync) begin
      @(posedge clk); #1;
    end
    a = v.a; b = v.b; op_sqrt = v.sq; exp_odd = v.e; start = 1'b1;
    e = model(v.a, v.b, v.sq, v.e);
    e.t0 = cyc;
    chk("model_result", 64'(e.res), 64'(v.hres));
    chk("model_sticky", 64'(e.st), 64'(v.hst));
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = MW'($urandom); b = MW'($urandom);
    op_sqrt = 1'($urandom); exp_odd = 1'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) return;
    end
    n_cmp++;
    n_fail++;
    $display("FAIL done_timeout: got done=0 after 200 cycles, expected done=1");
  endtask

  task automatic do_ack(input int hold);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
  endtask

  task automatic chk_quiet(input string nm, input int n);
    bit seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk(nm, 64'(seen), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_result"}, 64'(result), 64'd0);
    chk({nm, "_sticky"}, 64'(sticky), 64'd0);
    chk({nm, "_div_zero"}, 64'(div_zero), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{24'hC00000, 24'h800000, 1'b0, 1'b0, 26'h3000000, 1'b0};
    vecs[1] = '{24'h800000, 24'hC00000, 1'b0, 1'b0, 26'h1555555, 1'b1};
    vecs[2] = '{24'h800000, 24'h000000, 1'b1, 1'b0, 26'h2000000, 1'b0};
    vecs[3] = '{24'h800000, 24'h123456, 1'b1, 1'b1, 26'h2D413CC, 1'b1};
    vecs[4] = '{24'h900000, 24'h000000, 1'b1, 1'b1, 26'h3000000, 1'b0};
    vecs[5] = '{24'hFFFFFF, 24'h800000, 1'b0, 1'b0, 26'h3FFFFFC, 1'b0};
    vecs[6] = '{24'h800000, 24'hFFFFFF, 1'b0, 1'b0, 26'h1000001, 1'b1};
    vecs[7] = '{24'h800000, 24'h800000, 1'b0, 1'b0, 26'h2000000, 1'b0};
    vecs[8] = '{24'hFFFFFF, 24'h000000, 1'b1, 1'b1, 26'h3FFFFFD, 1'b1};
    vecs[9] = '{24'hC00000, 24'h000000, 1'b0, 1'b0, 26'h3FFFFFF, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    arst = 1'b0;

    // Directed vectors; after the first, each start follows its predecessor's ack back-to-back.
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i], i == 0);
      wait_done();
      do_ack(i == 1 ? 10 : 0);
    end

    // Start and ack while iterating must both be ignored.
    start_op(vecs[1], 1'b0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    start = 1'b1; a = 24'hC00000; b = 24'h800000; op_sqrt = 1'b0; ack = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ack = 1'b0;
    wait_done();
    do_ack(0);
    chk_quiet("no_queued_start_iter", 40);

    // Divide by zero, with a start pulse while the result is held.
    start_op(vecs[9], 1'b1);
    wait_done();
    @(posedge clk); #1;
    start = 1'b1; a = 24'h800000; b = 24'hC00000;
    @(posedge clk); #1;
    start = 1'b0;
    do_ack(8);
    chk_quiet("no_queued_start_valid", 40);

    // Asynchronous reset in the middle of an iteration.
    start_op(vecs[0], 1'b1);
    repeat (10) @(posedge clk);
    #3 arst = 1'b1;
    #1;
    chk_zero_outputs("midreset");
    @(posedge clk); #2 arst = 1'b0;
    chk_quiet("after_midreset", 35);

    start_op(vecs[6], 1'b1);
    wait_done();
    do_ack(0);

    repeat (3) @(posedge clk);
    chk("all_ops_completed", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
